// File: rtl/dot8_pe_sequencer_if.sv
// Purpose : handshake/bus bundle between dot8_pe_sequencer, its producer,
//           its consumer and the external PE array.
// Ports   : upstream valid_in/ready_in/data_in/tag_in, PE-side pe_enable/
//           pe_data_in/pe_data_out, downstream valid_out/ready_out/data_out/tag_out.
//           Modport slave is the sequencer's view; master is the environment's.
interface dot8_pe_sequencer_if #(
    parameter int NUM_LANES      = 4,
    parameter int NUM_PES        = 2,
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int TAG_WIDTH      = 8
);
    // Upstream packet
    logic                                valid_in;
    logic [NUM_LANES*DATA_IN_WIDTH-1:0]  data_in;
    logic [TAG_WIDTH-1:0]                tag_in;
    logic                                ready_in;

    // External PE array
    logic                                pe_enable;
    logic [NUM_PES*DATA_IN_WIDTH-1:0]    pe_data_in;
    logic [NUM_PES*DATA_OUT_WIDTH-1:0]   pe_data_out;

    // Downstream result
    logic                                valid_out;
    logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out;
    logic [TAG_WIDTH-1:0]                tag_out;
    logic                                ready_out;

    modport slave (
        input  valid_in,
        input  data_in,
        input  tag_in,
        output ready_in,
        output pe_enable,
        output pe_data_in,
        input  pe_data_out,
        output valid_out,
        output data_out,
        output tag_out,
        input  ready_out
    );

    modport master (
        output valid_in,
        output data_in,
        output tag_in,
        input  ready_in,
        input  pe_enable,
        input  pe_data_in,
        output pe_data_out,
        input  valid_out,
        input  data_out,
        input  tag_out,
        output ready_out
    );
endinterface

// File: rtl/dot8_pe_sequencer.sv
// Purpose : time-multiplexes one NUM_LANES operand packet onto NUM_PES external
//           PEs in B = NUM_LANES/NUM_PES batches and reassembles lane-ordered results.
// Latency : valid_out rises B+LATENCY+1 cycles after the accept edge (5 by default).
// Backpr. : one packet in flight; ready_in low while busy, result held until
//           ready_out, and a waiting packet is accepted on the retire edge (no bubble).
// Ports   : clk, reset (async, active-high), bus (dot8_pe_sequencer_if.slave).
module dot8_pe_sequencer #(
    parameter int NUM_LANES      = 4,
    parameter int NUM_PES        = 2,
    parameter int LATENCY        = 2,
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    dot8_pe_sequencer_if.slave      bus
);

    localparam int B  = NUM_LANES / NUM_PES;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    // Buffers are sized to the full index range so the batch index never
    // needs narrowing, even when B == 1 or B is not a power of two.
    localparam int BD = 1 << BW;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DI = DATA_IN_WIDTH;
    localparam int DO = DATA_OUT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          batch_q, batch_d;
    logic [LW-1:0]          drain_q, drain_d;

    logic [TAG_WIDTH-1:0]   tag_q;
    logic [DI-1:0]          op_q  [BD][NUM_PES];
    logic [DO-1:0]          res_q [BD][NUM_PES];

    // Issue-tracking delay line: mirrors the PE pipeline so each returning
    // result knows which batch (and therefore which lanes) it belongs to.
    logic                   dl_vld_q [LATENCY];
    logic [BW-1:0]          dl_idx_q [LATENCY];

    logic                   accept;
    logic                   issue;
    logic                   ready_in;
    logic                   pe_enable;
    logic                   valid_out;
    logic                   tap_vld;
    logic [BW-1:0]          tap_idx;
    logic [NUM_PES*DI-1:0]  pe_data_in;
    logic [NUM_LANES*DO-1:0] data_out;

    // ------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        batch_d   = batch_q;
        drain_d   = drain_q;
        accept    = 1'b0;
        issue     = 1'b0;
        ready_in  = 1'b0;
        pe_enable = 1'b0;
        valid_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_in = 1'b1;
                if (bus.valid_in) begin
                    accept  = 1'b1;
                    batch_d = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                pe_enable = 1'b1;
                issue     = 1'b1;
                if (batch_q == BW'(B - 1)) begin
                    // Drain counter counts down LATENCY-1..0, i.e. LATENCY cycles.
                    drain_d = LW'(LATENCY - 1);
                    state_d = S_DRAIN;
                end else begin
                    batch_d = batch_q + BW'(1);
                end
            end

            S_DRAIN: begin
                // Keep the PEs advancing with zero operands so the last batch
                // reaches the output taps.
                pe_enable = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_OUTPUT;
                end else begin
                    drain_d = drain_q - LW'(1);
                end
            end

            S_OUTPUT: begin
                valid_out = 1'b1;
                if (bus.ready_out) begin
                    // Retiring frees the operand/result buffers this edge, so a
                    // waiting packet can be taken without an idle cycle.
                    ready_in = 1'b1;
                    if (bus.valid_in) begin
                        accept  = 1'b1;
                        batch_d = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            batch_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            batch_q <= batch_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand and tag capture on accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
            for (int b = 0; b < BD; b++) begin
                for (int j = 0; j < NUM_PES; j++) begin
                    op_q[b][j] <= '0;
                end
            end
        end else if (accept) begin
            tag_q <= bus.tag_in;
            for (int b = 0; b < B; b++) begin
                for (int j = 0; j < NUM_PES; j++) begin
                    op_q[b][j] <= bus.data_in[(b*NUM_PES+j)*DI +: DI];
                end
            end
        end
    end

    // PE operands: batch[batch_q] while issuing, zeros otherwise.
    always_comb begin
        pe_data_in = '0;
        if (issue) begin
            for (int j = 0; j < NUM_PES; j++) begin
                pe_data_in[j*DI +: DI] = op_q[batch_q][j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue delay line; advances in lock-step with the PE pipelines
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_idx_q[i] <= '0;
            end
        end else if (pe_enable) begin
            dl_vld_q[0] <= issue;
            dl_idx_q[0] <= batch_q;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
        end
    end

    // The tap only lines up with pe_data_out while the PEs are advancing.
    assign tap_vld = dl_vld_q[LATENCY-1] & pe_enable;
    assign tap_idx = dl_idx_q[LATENCY-1];

    // ------------------------------------------------------------------
    // Result buffer: written only by returning PE results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BD; b++) begin
                for (int j = 0; j < NUM_PES; j++) begin
                    res_q[b][j] <= '0;
                end
            end
        end else if (tap_vld) begin
            for (int j = 0; j < NUM_PES; j++) begin
                res_q[tap_idx][j] <= bus.pe_data_out[j*DO +: DO];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int b = 0; b < B; b++) begin
            for (int j = 0; j < NUM_PES; j++) begin
                data_out[(b*NUM_PES+j)*DO +: DO] = res_q[b][j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.ready_in   = ready_in;
    assign bus.pe_enable  = pe_enable;
    assign bus.pe_data_in = pe_data_in;
    assign bus.valid_out  = valid_out;
    assign bus.data_out   = data_out;
    assign bus.tag_out    = tag_q;

endmodule

// File: tb/tb_dot8_pe_sequencer.sv
// Directed bench for dot8_pe_sequencer: a default instance (2 PEs, latency 2)
// and a wide instance (4 PEs, latency 1), each fed by a simple adder PE model
// (result = rs1 + rs2) pipelined on pe_enable.
module tb_dot8_pe_sequencer;

    localparam int LANES = 4;
    localparam int DI    = 64;
    localparam int DO    = 32;
    localparam int TW    = 8;
    localparam int PES_A = 2;
    localparam int LAT_A = 2;
    localparam int PES_B = 4;
    localparam int LAT_B = 1;

    // Packed lane vectors, lane 0 in the low bits.
    localparam logic [127:0] P1_RS1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] P1_RS2 = {32'd40, 32'd30, 32'd20, 32'd10};
    localparam logic [127:0] EXP1   = {32'd44, 32'd33, 32'd22, 32'd11};
    localparam logic [127:0] P3_RS1 = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] P_ZERO = '0;
    localparam logic [127:0] EXP3   = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] PJ_RS1 = {4{32'h0BAD_0BAD}};
    localparam logic [127:0] PJ_RS2 = {4{32'h1000_0001}};
    localparam logic [127:0] P5_RS1 = {32'd400, 32'd300, 32'd200, 32'd100};
    localparam logic [127:0] P5_RS2 = {32'd1, 32'd1, 32'd1, 32'd1};
    localparam logic [127:0] P6_RS1 = {32'd12, 32'd11, 32'd10, 32'd9};
    localparam logic [127:0] P6_RS2 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] EXP6   = {32'd16, 32'd14, 32'd12, 32'd10};
    // Batch operands for the default instance, {lane1, lane0} / {lane3, lane2}.
    localparam logic [127:0] EXP_B0 = {32'd20, 32'd2, 32'd10, 32'd1};
    localparam logic [127:0] EXP_B1 = {32'd40, 32'd4, 32'd30, 32'd3};

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    dot8_pe_sequencer_if #(.NUM_LANES(LANES), .NUM_PES(PES_A), .DATA_IN_WIDTH(DI),
                           .DATA_OUT_WIDTH(DO), .TAG_WIDTH(TW)) a ();
    dot8_pe_sequencer_if #(.NUM_LANES(LANES), .NUM_PES(PES_B), .DATA_IN_WIDTH(DI),
                           .DATA_OUT_WIDTH(DO), .TAG_WIDTH(TW)) b ();

    dot8_pe_sequencer #(.NUM_LANES(LANES), .NUM_PES(PES_A), .LATENCY(LAT_A),
                        .DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO), .TAG_WIDTH(TW))
        u_dut_a (.clk(clk), .reset(rst), .bus(a));

    dot8_pe_sequencer #(.NUM_LANES(LANES), .NUM_PES(PES_B), .LATENCY(LAT_B),
                        .DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO), .TAG_WIDTH(TW))
        u_dut_b (.clk(clk), .reset(rst), .bus(b));

    // ---------------- PE models ----------------
    logic [DO-1:0] pipe_a [LAT_A][PES_A];
    logic [DO-1:0] pipe_b [LAT_B][PES_B];

    always @(posedge clk) begin
        if (a.pe_enable === 1'b1) begin
            for (int j = 0; j < PES_A; j++) begin
                for (int s = LAT_A - 1; s > 0; s--) pipe_a[s][j] <= pipe_a[s-1][j];
                pipe_a[0][j] <= a.pe_data_in[j*DI +: 32] + a.pe_data_in[j*DI+32 +: 32];
            end
        end
    end

    always @(posedge clk) begin
        if (b.pe_enable === 1'b1) begin
            for (int j = 0; j < PES_B; j++) begin
                for (int s = LAT_B - 1; s > 0; s--) pipe_b[s][j] <= pipe_b[s-1][j];
                pipe_b[0][j] <= b.pe_data_in[j*DI +: 32] + b.pe_data_in[j*DI+32 +: 32];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < PES_A; j++) a.pe_data_out[j*DO +: DO] = pipe_a[LAT_A-1][j];
    end

    always_comb begin
        for (int j = 0; j < PES_B; j++) b.pe_data_out[j*DO +: DO] = pipe_b[LAT_B-1][j];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [LANES*DI-1:0] mk_data(input logic [127:0] rs1v,
                                                    input logic [127:0] rs2v);
        logic [LANES*DI-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*DI +: DI] = {rs2v[i*32 +: 32], rs1v[i*32 +: 32]};
        return d;
    endfunction

    task automatic send(input bit sel, input logic [LANES*DI-1:0] d, input logic [TW-1:0] t);
        if (sel) begin
            b.valid_in = 1'b1; b.data_in = d; b.tag_in = t;
        end else begin
            a.valid_in = 1'b1; a.data_in = d; a.tag_in = t;
        end
    endtask

    // Waits (bounded) for valid_out; n is the cycle index after the accept
    // edge, 0 if it never came. Returns at the negedge of that cycle.
    task automatic wait_valid(input bit sel, input int start, output int n);
        n = 0;
        for (int k = start + 1; k <= start + 20; k++) begin
            @(negedge clk);
            if ((sel ? b.valid_out : a.valid_out) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (a.valid_out !== 1'b0) begin tests_failed++; $display("FAIL rst_valid_out: got %b want 0", a.valid_out); end
        tests_run++;
        if (a.pe_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_pe_enable: got %b want 0", a.pe_enable); end
        tests_run++;
        if (a.pe_data_in !== '0) begin tests_failed++; $display("FAIL rst_pe_data_in: got %h want 0", a.pe_data_in); end
        tests_run++;
        if (a.data_out !== '0) begin tests_failed++; $display("FAIL rst_data_out: got %h want 0", a.data_out); end
        tests_run++;
        if (a.tag_out !== '0) begin tests_failed++; $display("FAIL rst_tag_out: got %h want 0", a.tag_out); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_in_a: got %b want 1", a.ready_in); end
        tests_run++;
        if (b.ready_in !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_in_b: got %b want 1", b.ready_in); end
    endtask

    task automatic test_single();
        int n;
        @(posedge clk); #1;
        a.ready_out = 1'b1;
        send(1'b0, mk_data(P1_RS1, P1_RS2), 8'h5A);
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b1) begin tests_failed++; $display("FAIL single_ready_c0: got %b want 1", a.ready_in); end
        @(posedge clk); #1 a.valid_in = 1'b0;
        @(negedge clk);   // c1: batch 0
        tests_run++;
        if (a.pe_enable !== 1'b1 || a.pe_data_in !== EXP_B0 || a.ready_in !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_issue_b0: en=%b rdy=%b pe_in=%h want en=1 rdy=0 pe_in=%h",
                     a.pe_enable, a.ready_in, a.pe_data_in, EXP_B0);
        end
        @(negedge clk);   // c2: batch 1
        tests_run++;
        if (a.pe_enable !== 1'b1 || a.pe_data_in !== EXP_B1) begin
            tests_failed++;
            $display("FAIL single_issue_b1: en=%b pe_in=%h want en=1 pe_in=%h", a.pe_enable, a.pe_data_in, EXP_B1);
        end
        @(negedge clk);   // c3: drain
        tests_run++;
        if (a.pe_enable !== 1'b1 || a.pe_data_in !== '0 || a.valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: en=%b pe_in=%h vld=%b want en=1 pe_in=0 vld=0",
                     a.pe_enable, a.pe_data_in, a.valid_out);
        end
        wait_valid(1'b0, 3, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL single_latency: got %0d want 5", n); end
        tests_run++;
        if (a.data_out !== EXP1) begin tests_failed++; $display("FAIL single_data: got %h want %h", a.data_out, EXP1); end
        tests_run++;
        if (a.tag_out !== 8'h5A) begin tests_failed++; $display("FAIL single_tag: got %h want 5a", a.tag_out); end
        tests_run++;
        if (a.pe_enable !== 1'b0) begin tests_failed++; $display("FAIL single_output_pe_en: got %b want 0", a.pe_enable); end
        @(negedge clk);
        tests_run++;
        if (a.valid_out !== 1'b0 || a.ready_in !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_one_cycle: vld=%b rdy=%b want vld=0 rdy=1", a.valid_out, a.ready_in);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(posedge clk); #1;
        a.ready_out = 1'b0;
        send(1'b0, mk_data(P1_RS1, P1_RS2), 8'h5A);
        @(posedge clk); #1 a.valid_in = 1'b0;
        wait_valid(1'b0, 0, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL bp_latency: got %0d want 5", n); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            tests_run++;
            if (a.valid_out !== 1'b1 || a.ready_in !== 1'b0 || a.data_out !== EXP1 || a.tag_out !== 8'h5A) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b data=%h tag=%h want vld=1 rdy=0 data=%h tag=5a",
                         i, a.valid_out, a.ready_in, a.data_out, a.tag_out, EXP1);
            end
        end
        @(posedge clk); #1 a.ready_out = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a.valid_out !== 1'b1 || a.ready_in !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: vld=%b rdy=%b want vld=1 rdy=1", a.valid_out, a.ready_in);
        end
        @(negedge clk);
        tests_run++;
        if (a.valid_out !== 1'b0) begin tests_failed++; $display("FAIL bp_retired: got %b want 0", a.valid_out); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        a.ready_out = 1'b0;
        send(1'b0, mk_data(P1_RS1, P1_RS2), 8'h5A);
        @(posedge clk); #1 a.valid_in = 1'b0;
        wait_valid(1'b0, 0, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d want 5", n); end
        @(posedge clk); #1;
        send(1'b0, mk_data(P3_RS1, P_ZERO), 8'h11);
        a.ready_out = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b1 || a.data_out !== EXP1 || a.tag_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL b2b_handover: rdy=%b data=%h tag=%h want rdy=1 data=%h tag=5a",
                     a.ready_in, a.data_out, a.tag_out, EXP1);
        end
        @(posedge clk); #1 a.valid_in = 1'b0;
        wait_valid(1'b0, 0, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d want 5", n); end
        tests_run++;
        if (a.data_out !== EXP3 || a.tag_out !== 8'h11) begin
            tests_failed++;
            $display("FAIL b2b_second_data: data=%h tag=%h want data=%h tag=11", a.data_out, a.tag_out, EXP3);
        end
    endtask

    task automatic test_busy_drop();
        int n;
        @(posedge clk); #1;
        a.ready_out = 1'b1;
        send(1'b0, mk_data(P1_RS1, P1_RS2), 8'h5A);
        @(posedge clk); #1;
        send(1'b0, mk_data(PJ_RS1, PJ_RS2), 8'hEE);
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b0) begin tests_failed++; $display("FAIL drop_ready_c1: got %b want 0", a.ready_in); end
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b0) begin tests_failed++; $display("FAIL drop_ready_c2: got %b want 0", a.ready_in); end
        @(posedge clk); #1 a.valid_in = 1'b0;
        wait_valid(1'b0, 2, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL drop_latency: got %0d want 5", n); end
        tests_run++;
        if (a.data_out !== EXP1 || a.tag_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL drop_data: data=%h tag=%h want data=%h tag=5a", a.data_out, a.tag_out, EXP1);
        end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        @(posedge clk); #1;
        a.ready_out = 1'b1;
        send(1'b0, mk_data(P5_RS1, P5_RS2), 8'h77);
        @(posedge clk); #1 a.valid_in = 1'b0;   // c1
        @(posedge clk); #1;                      // c2
        @(posedge clk); #1 rst = 1'b1;           // c3, first drain cycle
        @(negedge clk);
        tests_run++;
        if (a.valid_out !== 1'b0 || a.pe_enable !== 1'b0 || a.pe_data_in !== '0) begin
            tests_failed++;
            $display("FAIL mid_rst_ctrl: vld=%b en=%b pe_in=%h want 0/0/0", a.valid_out, a.pe_enable, a.pe_data_in);
        end
        tests_run++;
        if (a.data_out !== '0 || a.tag_out !== '0) begin
            tests_failed++;
            $display("FAIL mid_rst_data: data=%h tag=%h want 0/0", a.data_out, a.tag_out);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a.ready_in !== 1'b1 || a.valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_rst_release: rdy=%b vld=%b want rdy=1 vld=0", a.ready_in, a.valid_out);
        end
        @(posedge clk); #1;
        send(1'b0, mk_data(P6_RS1, P6_RS2), 8'h33);
        @(posedge clk); #1 a.valid_in = 1'b0;
        wait_valid(1'b0, 0, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL mid_rst_latency: got %0d want 5", n); end
        tests_run++;
        if (a.data_out !== EXP6 || a.tag_out !== 8'h33) begin
            tests_failed++;
            $display("FAIL mid_rst_fresh: data=%h tag=%h want data=%h tag=33", a.data_out, a.tag_out, EXP6);
        end
    endtask

    task automatic test_single_batch();
        int n;
        @(posedge clk); #1;
        b.ready_out = 1'b1;
        send(1'b1, mk_data(P1_RS1, P1_RS2), 8'h5A);
        @(posedge clk); #1 b.valid_in = 1'b0;
        @(negedge clk);   // c1: the only issue cycle
        tests_run++;
        if (b.pe_enable !== 1'b1 || b.pe_data_in !== mk_data(P1_RS1, P1_RS2)) begin
            tests_failed++;
            $display("FAIL wide_issue: en=%b pe_in=%h", b.pe_enable, b.pe_data_in);
        end
        @(negedge clk);   // c2: drain
        tests_run++;
        if (b.pe_enable !== 1'b1 || b.pe_data_in !== '0 || b.valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_drain: en=%b pe_in=%h vld=%b want 1/0/0", b.pe_enable, b.pe_data_in, b.valid_out);
        end
        wait_valid(1'b1, 2, n);
        tests_run++;
        if (n !== 3) begin tests_failed++; $display("FAIL wide_latency: got %0d want 3", n); end
        tests_run++;
        if (b.data_out !== EXP1 || b.tag_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL wide_data: data=%h tag=%h want data=%h tag=5a", b.data_out, b.tag_out, EXP1);
        end
        @(negedge clk);
        tests_run++;
        if (b.valid_out !== 1'b0) begin tests_failed++; $display("FAIL wide_retired: got %b want 0", b.valid_out); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        a.valid_in   = 1'b0; a.data_in = '0; a.tag_in = '0; a.ready_out = 1'b0;
        b.valid_in   = 1'b0; b.data_in = '0; b.tag_in = '0; b.ready_out = 1'b0;

        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid_drain();
        test_single_batch();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dot8_pe_sequencer.md
Name: dot8_pe_sequencer

Overview:
Upstream/downstream wrapper for the dot8 ALU processing elements (PEs). It accepts one NUM_LANES-wide operand packet, time-multiplexes it onto NUM_PES PEs in NUM_LANES/NUM_PES consecutive batches, and collects the fixed-latency PE results into a lane-ordered output buffer. It then presents the full result with its tag on a valid/ready commit handshake. It sits between execute dispatch and commit; the PE array is external.

Parameters:
NUM_LANES, 4, lanes per packet; must be a multiple of NUM_PES.
NUM_PES, 2, PE instances driven in parallel; 1 <= NUM_PES <= NUM_LANES.
LATENCY, 2, PE pipeline depth in enabled cycles; must be >= 1.
DATA_IN_WIDTH, 64, per-lane operand width ({rs2, rs1}).
DATA_OUT_WIDTH, 32, per-lane result width.
TAG_WIDTH, 8, opaque sideband (uuid/wid/tmask/PC/rd/...).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
valid_in  in  1  input packet valid.
data_in  in  NUM_LANES*DATA_IN_WIDTH  operands; lane i occupies slice i.
tag_in  in  TAG_WIDTH  sideband travelling with the packet.
ready_in  out  1  packet accepted when valid_in && ready_in.
pe_enable  out  1  advance enable for the external PE pipelines.
pe_data_in  out  NUM_PES*DATA_IN_WIDTH  current batch operands; PE j occupies slice j.
pe_data_out  in  NUM_PES*DATA_OUT_WIDTH  PE results, LATENCY enabled cycles after issue.
valid_out  out  1  result packet valid.
data_out  out  NUM_LANES*DATA_OUT_WIDTH  lane-ordered results.
tag_out  out  TAG_WIDTH  tag of the result packet.
ready_out  in  1  consumer ready.

Behaviour:
- B = NUM_LANES/NUM_PES batches. Batch k drives PE j with input lane k*NUM_PES+j.
- States:
  - IDLE: ready_in=1, pe_enable=0.
  - ISSUE: B cycles; batch counter runs 0..B-1.
  - DRAIN: LATENCY cycles.
  - OUTPUT: valid_out=1.
- Accept: on valid_in && ready_in, register data_in and tag_in, clear batch counter, go to ISSUE. valid_in while not ready is ignored; no capture.
- ISSUE:
  - pe_enable=1; pe_data_in = registered batch[counter].
  - At counter==B-1, go to DRAIN.
  - When B==1, ISSUE lasts exactly one cycle.
- DRAIN:
  - pe_enable=1; pe_data_in = 0.
  - A down-counter reaches 0 after LATENCY cycles, then go to OUTPUT.
- Capture:
  - A LATENCY-deep delay line carries {issue_valid, batch index}; it shifts on every pe_enable cycle.
  - When its tap is valid, pe_data_out slice j is written to data_out lane idx*NUM_PES+j at that clock edge.
- Latency: the accept edge ends cycle c0; valid_out is high from cycle c0+B+LATENCY+1. Default config: 5 cycles.
- OUTPUT:
  - valid_out=1; data_out and tag_out are held stable until ready_out=1.
  - On ready_out: if valid_in is also high, ready_in=1 in the same cycle; the new packet is accepted and the state goes to ISSUE with no bubble. Otherwise go to IDLE.
  - ready_in = (state==IDLE) || (state==OUTPUT && ready_out).
- pe_enable=0 in IDLE and OUTPUT, so PE contents freeze; no results are expected then.
- Reset (async, any state, including mid-ISSUE/DRAIN):
  - State goes to IDLE; all counters and the delay line are cleared; in-flight PE results are discarded.
  - Output values during reset: valid_out=0, ready_in=1 after reset deasserts, pe_enable=0, pe_data_in=0, data_out=0, tag_out=0.
- data_out lanes are written only by capture, so all lanes are overwritten each packet.

Test Plan:
Bench PE model: result = rs1[31:0] + rs2[63:32], pipelined LATENCY stages advancing on pe_enable. Default params unless stated.
1. Single packet: lanes rs1={1,2,3,4}, rs2={10,20,30,40}, tag 0x5A, ready_out=1 -> valid_out exactly 5 cycles after accept; data_out={11,22,33,44}; tag_out=0x5A; valid_out high 1 cycle.
2. Back-pressure: as test 1 with ready_out=0 for 6 cycles -> valid_out, data_out, tag_out stable; ready_in=0 throughout; retire on the first ready_out=1.
3. Back-to-back: a second packet (rs1={5,6,7,8}, rs2=0, tag 0x11) is held valid during OUTPUT of the first -> accepted on the same edge the first retires; second valid_out 5 cycles later with {5,6,7,8}/0x11.
4. Busy drop: valid_in pulsed with a junk packet during ISSUE -> not captured; output equals the first packet only.
5. Reset mid-DRAIN: assert reset in cycle c3 -> valid_out=0, data_out=0, pe_enable=0 immediately; a fresh packet after release completes with correct data and no stale lanes.
6. NUM_PES=4, LATENCY=1: test 1 stimulus -> one ISSUE cycle; valid_out 3 cycles after accept; data_out={11,22,33,44}.
